// File: rtl/sr_flag_arbiter_if.sv
// Command/grant bundle between the control agents (master) and the SR flag
// arbiter (slave).
interface sr_flag_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
);
    localparam int IW  = (NFLAG > 1) ? $clog2(NFLAG) : 1;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                 en;
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_cmd;
    logic [IW*NREQ-1:0]   req_idx;
    logic [NREQ-1:0]      req_ready;
    logic [NFLAG-1:0]     flags;
    logic                 gnt_valid;
    logic [IDW-1:0]       gnt_id;
    logic                 err;

    modport master (
        output en, req_valid, req_cmd, req_idx,
        input  req_ready, flags, gnt_valid, gnt_id, err
    );

    modport slave (
        input  en, req_valid, req_cmd, req_idx,
        output req_ready, flags, gnt_valid, gnt_id, err
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one set/clear/toggle command per cycle onto a
// shared flag bank; the bank is written as whole bits, so S=R=1 never arises.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
) (
    input  logic             clk,
    input  logic             rst,
    sr_flag_arbiter_if.slave bus
);
    localparam int IW  = (NFLAG > 1) ? $clog2(NFLAG) : 1;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]   ptr;
    logic [NFLAG-1:0] flag_bank;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_id;
    logic             err;

    logic [NREQ-1:0]  ready;
    logic [IDW-1:0]   sel;
    logic             found;
    logic [1:0]       sel_cmd;
    logic [IW-1:0]    sel_idx;
    logic             idx_ok;
    int               j;

    function automatic logic [NFLAG-1:0] apply_cmd(
        input logic [NFLAG-1:0] cur,
        input logic [1:0]       cmd,
        input logic [IW-1:0]    idx
    );
        logic [NFLAG-1:0] nxt;
        nxt = cur;
        for (int b = 0; b < NFLAG; b++) begin
            if (IW'(b) == idx) begin
                case (cmd)
                    2'b01:   nxt[b] = 1'b1;
                    2'b10:   nxt[b] = 1'b0;
                    2'b11:   nxt[b] = ~cur[b];
                    default: nxt[b] = cur[b];
                endcase
            end
        end
        return nxt;
    endfunction

    // Scan from ptr upward with wrap; reset and en gate every grant.
    always_comb begin
        ready = '0;
        sel   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && rst && bus.en && bus.req_valid[j]) begin
                found    = 1'b1;
                ready[j] = 1'b1;
                sel      = IDW'(j);
            end
        end
    end

    assign sel_cmd = bus.req_cmd[2*int'(sel) +: 2];
    assign sel_idx = bus.req_idx[IW*int'(sel) +: IW];
    assign idx_ok  = (int'(sel_idx) < NFLAG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_bank <= '0;
            ptr       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            err       <= 1'b0;
        end else if (found) begin
            if (idx_ok) flag_bank <= apply_cmd(flag_bank, sel_cmd, sel_idx);
            ptr       <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
            gnt_id    <= sel;
            gnt_valid <= 1'b1;
            err       <= ~idx_ok;
        end else begin
            gnt_valid <= 1'b0;
            err       <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.flags     = flag_bank;
    assign bus.gnt_valid = gnt_valid;
    assign bus.gnt_id    = gnt_id;
    assign bus.err       = err;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: an 8-flag instance checked against a rule-level
// model, plus a 6-flag instance for out-of-range indices.
module tb_sr_flag_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;

    sr_flag_arbiter_if #(.NREQ(N), .NFLAG(8)) bus8 ();
    sr_flag_arbiter_if #(.NREQ(N), .NFLAG(6)) bus6 ();

    sr_flag_arbiter #(.NREQ(N), .NFLAG(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    sr_flag_arbiter #(.NREQ(N), .NFLAG(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model of the 8-flag instance
    bit [7:0] m_flags;
    int       m_ptr;
    bit       m_gv;
    int       m_gid;
    bit       m_err;

    task automatic model_reset();
        m_flags = '0; m_ptr = 0; m_gv = 0; m_gid = 0; m_err = 0;
    endtask

    // Winner is the valid requester with the smallest distance ahead of ptr.
    function automatic int exp_grant();
        int best = -1;
        int bestd = N;
        if (!bus8.en) return -1;
        for (int i = 0; i < N; i++) begin
            int d = (i - m_ptr + N) % N;
            if (bus8.req_valid[i] && d < bestd) begin
                best = i; bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_accept(input int g);
        bit [1:0] c;
        int       ix;
        if (g < 0) begin
            m_gv = 0; m_err = 0;
        end else begin
            c  = bus8.req_cmd[2*g +: 2];
            ix = int'(bus8.req_idx[3*g +: 3]);
            if (c == 2'b01) m_flags[ix] = 1'b1;
            else if (c == 2'b10) m_flags[ix] = 1'b0;
            else if (c == 2'b11) m_flags[ix] = ~m_flags[ix];
            m_ptr = (g + 1) % N;
            m_gid = g; m_gv = 1; m_err = 0;
        end
    endtask

    function automatic logic [3:0] onehot(input int g);
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    task automatic tick8(input int g);
        @(posedge clk);
        model_accept(g);
        #1;
    endtask

    task automatic tick6();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus8.en = 1'b1; bus8.req_valid = 4'hF; bus8.req_cmd = '0; bus8.req_idx = '0;
        bus6.en = 1'b1; bus6.req_valid = 4'hF; bus6.req_cmd = '0; bus6.req_idx = '0;
        @(posedge clk); #1;
        tests_run++;
        if (bus8.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready8: got %b expected 0000", bus8.req_ready); end
        tests_run++;
        if (bus6.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready6: got %b expected 0000", bus6.req_ready); end
        tests_run++;
        if (bus8.flags !== 8'h00) begin tests_failed++; $display("FAIL reset_flags: got %h expected 00", bus8.flags); end
        tests_run++;
        if ({bus8.gnt_valid, bus8.err, bus8.gnt_id} !== 4'b0000) begin tests_failed++;
            $display("FAIL reset_gnt: got gv=%b err=%b id=%0d expected 0 0 0", bus8.gnt_valid, bus8.err, bus8.gnt_id); end
        bus6.req_valid = 4'h0;
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (bus8.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL release_ready: got %b expected 0001", bus8.req_ready); end
        tick8(exp_grant());
        tests_run++;
        if (bus8.gnt_valid !== 1'b1 || bus8.gnt_id !== 2'd0) begin tests_failed++;
            $display("FAIL release_gnt: got gv=%b id=%0d expected 1 0", bus8.gnt_valid, bus8.gnt_id); end
        bus8.req_valid = 4'h0;
        tick8(-1);
    endtask

    task automatic test_single();
        logic [1:0] cmds [3] = '{2'b01, 2'b11, 2'b10};
        int         idxs [3] = '{5, 5, 3};
        logic [7:0] expf [3] = '{8'h20, 8'h00, 8'h00};
        for (int k = 0; k < 3; k++) begin
            bus8.req_valid = 4'b0100;
            bus8.req_cmd[5:4] = cmds[k];
            bus8.req_idx[8:6] = 3'(idxs[k]);
            #1;
            tests_run++;
            if (bus8.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready[%0d]: got %b expected 0100", k, bus8.req_ready); end
            tick8(exp_grant());
            tests_run++;
            if (bus8.flags !== expf[k] || bus8.flags !== m_flags) begin tests_failed++;
                $display("FAIL single_flags[%0d]: got %h expected %h", k, bus8.flags, expf[k]); end
            tests_run++;
            if (bus8.gnt_valid !== 1'b1 || bus8.gnt_id !== 2'd2) begin tests_failed++;
                $display("FAIL single_gnt[%0d]: got gv=%b id=%0d expected 1 2", k, bus8.gnt_valid, bus8.gnt_id); end
        end
        bus8.req_valid = 4'h0;
        tick8(-1);
        tests_run++;
        if (bus8.gnt_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got gv=%b expected 0", bus8.gnt_valid); end
    endtask

    task automatic test_fairness();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        pulse_reset();
        bus8.en = 1'b1; bus8.req_valid = 4'hF; bus8.req_cmd = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests_run++;
            if (bus8.req_ready !== onehot(order[k]) || exp_grant() != order[k]) begin tests_failed++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", k, bus8.req_ready, onehot(order[k])); end
            tick8(exp_grant());
            tests_run++;
            if (bus8.gnt_id !== 2'(order[k]) || bus8.gnt_valid !== 1'b1) begin tests_failed++;
                $display("FAIL rr_gnt[%0d]: got id=%0d gv=%b expected %0d 1", k, bus8.gnt_id, bus8.gnt_valid, order[k]); end
        end
        bus8.req_valid = 4'h0;
        tick8(-1);
    endtask

    task automatic test_contention();
        pulse_reset();
        bus8.req_valid = 4'b1010;
        bus8.req_cmd[3:2] = 2'b01; bus8.req_idx[5:3]  = 3'd7;
        bus8.req_cmd[7:6] = 2'b10; bus8.req_idx[11:9] = 3'd7;
        #1;
        tests_run++;
        if (bus8.req_ready !== 4'b0010) begin tests_failed++; $display("FAIL cont_ready1: got %b expected 0010", bus8.req_ready); end
        tick8(exp_grant());
        tests_run++;
        if (bus8.flags[7] !== 1'b1 || bus8.gnt_id !== 2'd1 || $isunknown(bus8.flags)) begin tests_failed++;
            $display("FAIL cont_first: got flags=%h id=%0d expected flag7=1 id=1", bus8.flags, bus8.gnt_id); end
        bus8.req_valid = 4'b1000;
        #1;
        tests_run++;
        if (bus8.req_ready !== 4'b1000) begin tests_failed++; $display("FAIL cont_ready2: got %b expected 1000", bus8.req_ready); end
        tick8(exp_grant());
        tests_run++;
        if (bus8.flags[7] !== 1'b0 || bus8.gnt_id !== 2'd3 || $isunknown(bus8.flags)) begin tests_failed++;
            $display("FAIL cont_second: got flags=%h id=%0d expected flag7=0 id=3", bus8.flags, bus8.gnt_id); end
        bus8.req_valid = 4'h0;
        tick8(-1);
    endtask

    task automatic test_bad_index();
        pulse_reset();
        bus6.en = 1'b1; bus6.req_valid = 4'b0001;
        bus6.req_cmd[1:0] = 2'b01; bus6.req_idx[2:0] = 3'd7;
        #1;
        tests_run++;
        if (bus6.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL bad_ready: got %b expected 0001", bus6.req_ready); end
        tick6();
        tests_run++;
        if (bus6.err !== 1'b1 || bus6.gnt_valid !== 1'b1 || bus6.flags !== 6'h00 || bus6.gnt_id !== 2'd0) begin tests_failed++;
            $display("FAIL bad_accept: got err=%b gv=%b flags=%h id=%0d expected 1 1 00 0", bus6.err, bus6.gnt_valid, bus6.flags, bus6.gnt_id); end
        bus6.req_valid = 4'b0011;
        bus6.req_cmd[3:2] = 2'b01; bus6.req_idx[5:3] = 3'd5;
        #1;
        tests_run++;
        if (bus6.req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bad_ptr_adv: got %b expected 0010", bus6.req_ready); end
        tick6();
        tests_run++;
        if (bus6.err !== 1'b0 || bus6.flags !== 6'h20 || bus6.gnt_id !== 2'd1) begin tests_failed++;
            $display("FAIL bad_then_good: got err=%b flags=%h id=%0d expected 0 20 1", bus6.err, bus6.flags, bus6.gnt_id); end
        bus6.req_valid = 4'h0;
        tick6();
        tests_run++;
        if (bus6.err !== 1'b0 || bus6.gnt_valid !== 1'b0) begin tests_failed++;
            $display("FAIL bad_idle: got err=%b gv=%b expected 0 0", bus6.err, bus6.gnt_valid); end
    endtask

    task automatic test_random();
        logic [3:0] last_ready;
        int         g;
        bus8.en = 1'b1; bus8.req_valid = 4'h0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (!bus8.req_valid[r] || last_ready[r]) begin
                    bus8.req_valid[r]       = ($urandom_range(0, 2) != 0);
                    bus8.req_cmd[2*r +: 2]  = 2'($urandom_range(0, 3));
                    bus8.req_idx[3*r +: 3]  = 3'($urandom_range(0, 7));
                end else if ($urandom_range(0, 9) == 0) begin
                    bus8.req_valid[r] = 1'b0;
                end
            end
            bus8.en = ($urandom_range(0, 7) != 0);
            #1;
            g = exp_grant();
            last_ready = bus8.req_ready;
            tests_run++;
            if (bus8.req_ready !== onehot(g)) begin tests_failed++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, bus8.req_ready, onehot(g)); end
            tick8(g);
            tests_run++;
            if (bus8.flags !== m_flags || bus8.gnt_valid !== m_gv || bus8.gnt_id !== 2'(m_gid) || bus8.err !== m_err) begin tests_failed++;
                $display("FAIL rand_state[%0d]: got flags=%h gv=%b id=%0d err=%b expected %h %b %0d %b",
                         cyc, bus8.flags, bus8.gnt_valid, bus8.gnt_id, bus8.err, m_flags, m_gv, m_gid, m_err); end
        end
        bus8.en = 1'b1; bus8.req_valid = 4'h0;
        tick8(-1);
    endtask

    task automatic test_en_reset();
        logic [7:0] held;
        bus8.en = 1'b1; bus8.req_valid = 4'b0001;
        bus8.req_cmd[1:0] = 2'b01; bus8.req_idx[2:0] = 3'd6;
        #1;
        tick8(exp_grant());
        tests_run++;
        if (bus8.flags[6] !== 1'b1) begin tests_failed++; $display("FAIL en_preset: got flags=%h expected bit6 set", bus8.flags); end
        held = m_flags;
        bus8.en = 1'b0; bus8.req_valid = 4'hF; bus8.req_cmd = 8'hFF; bus8.req_idx = 12'hFAC;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (bus8.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL en_ready[%0d]: got %b expected 0000", k, bus8.req_ready); end
            tick8(exp_grant());
            tests_run++;
            if (bus8.flags !== held || bus8.gnt_valid !== 1'b0) begin tests_failed++;
                $display("FAIL en_hold[%0d]: got flags=%h gv=%b expected %h 0", k, bus8.flags, bus8.gnt_valid, held); end
        end
        bus8.en = 1'b1;
        #1;
        tests_run++;
        if (bus8.req_ready !== onehot(exp_grant())) begin tests_failed++;
            $display("FAIL en_resume: got %b expected %b", bus8.req_ready, onehot(exp_grant())); end
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus8.flags !== 8'h00 || bus8.req_ready !== 4'b0000 || bus8.gnt_valid !== 1'b0 || bus8.gnt_id !== 2'd0) begin tests_failed++;
            $display("FAIL midreset_now: got flags=%h ready=%b gv=%b id=%0d expected 00 0000 0 0",
                     bus8.flags, bus8.req_ready, bus8.gnt_valid, bus8.gnt_id); end
        @(posedge clk); #1;
        tests_run++;
        if (bus8.flags !== 8'h00 || bus8.gnt_valid !== 1'b0) begin tests_failed++;
            $display("FAIL midreset_edge: got flags=%h gv=%b expected 00 0", bus8.flags, bus8.gnt_valid); end
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (bus8.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL midreset_ptr: got %b expected 0001", bus8.req_ready); end
        bus8.req_valid = 4'h0;
        tick8(-1);
    endtask

    initial begin
        rst = 1'b1;
        bus8.en = 1'b0; bus8.req_valid = '0; bus8.req_cmd = '0; bus8.req_idx = '0;
        bus6.en = 1'b0; bus6.req_valid = '0; bus6.req_cmd = '0; bus6.req_idx = '0;
        model_reset();
        #2 rst = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_contention();
        test_bad_index();
        test_random();
        test_en_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Round-robin controller that shares one bank of SR-style flag bits between several requesters. Each requester issues set, clear, toggle or no-op commands against a flag index. The arbiter grants at most one command per cycle and applies it to the flag bank. It never presents a simultaneous set and reset to any flag, so the undefined S=R=1 condition of the underlying SR storage cannot occur. The block sits between the control agents and the SR flag storage used as status and lock bits in the datapath.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of flag bits (2..32)
- IW, $clog2(NFLAG), index width (derived, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- en  in  1  arbitration enable; 0 = no grants, flags hold
- req_valid  in  NREQ  per-requester command valid
- req_cmd  in  2*NREQ  per-requester command, requester i at [2i+1:2i]: 00 no-op, 01 set, 10 clear, 11 toggle
- req_idx  in  IW*NREQ  per-requester flag index, requester i at [IW*i+IW-1:IW*i]
- req_ready  out  NREQ  one-hot (or zero) grant, combinational
- flags  out  NFLAG  registered flag bank
- gnt_valid  out  1  registered, 1 for one cycle after any accepted command
- gnt_id  out  $clog2(NREQ) (min 1)  registered id of last accepted requester
- err  out  1  registered, 1 for one cycle after an accepted command with req_idx >= NFLAG

## Operation
- Reset (rst=0, asynchronous): flags=0, ptr=0, gnt_valid=0, gnt_id=0, err=0. req_ready is 0 while rst=0, regardless of inputs.
- Grant selection is combinational. If en=1 and any req_valid is set, scan the requesters starting at ptr upward, wrapping modulo NREQ. The first requester found with req_valid=1 gets req_ready=1. All other bits of req_ready are 0.
- Transfer: the command of requester i is accepted on a rising edge where req_valid[i] && req_ready[i]. The requester holds valid, cmd and idx stable until it is accepted. Dropping valid before acceptance is allowed and withdraws the command.
- On acceptance with idx < NFLAG:
  - 01: flags[idx] <= 1
  - 10: flags[idx] <= 0
  - 11: flags[idx] <= ~flags[idx]
  - 00: flags unchanged
  - All other flag bits hold.
- On acceptance with idx >= NFLAG: flags unchanged; err <= 1 for one cycle. The command is still consumed and ptr still advances.
- On acceptance: ptr <= (i+1) mod NREQ, gnt_id <= i, gnt_valid <= 1.
- No acceptance in a cycle: gnt_valid <= 0, err <= 0, ptr holds.
- en=0: req_ready=0, so no state changes except gnt_valid and err clearing to 0.

## Timing
- Grant is visible combinationally in the same cycle as the request.
- Flag update, gnt_valid, gnt_id and err all become visible one cycle after acceptance, all together.
- Throughput is one command per cycle.
- Worst-case wait for a continuously valid requester is NREQ-1 accepted commands (starvation-free).
- Back-to-back commands from the same requester can be accepted only when no other requester is valid. Otherwise the rotation gives the other requesters their turns first.
- A write to a flag in cycle N is seen by a command in cycle N+1; toggle-after-toggle returns the original value.
- Reset asserted mid-operation clears all state immediately. A command in flight is discarded (not applied).
- Reset deassertion is synchronized externally. The first grant can occur in the first cycle with rst=1.

## Test plan
- Reset: rst=0 with every req_valid=1 -> req_ready=0000, flags=0x00, gnt_valid=0. Release rst -> requester 0 is granted first.
- Single requester: requester 2 sends set idx 5, then toggle idx 5, then clear idx 3. Expected flags sequence: 0x20, 0x00, 0x00; gnt_id=2 each time; gnt_valid high for 3 cycles.
- Round-robin fairness: all 4 requesters valid continuously, each sending a no-op. Expected grant order 0,1,2,3,0,1. ptr wraps from 3 to 0; no requester waits more than 3 grants.
- Contention on one flag: requester 1 sets idx 7 and requester 3 clears idx 7 in the same cycle, with ptr=0. Expected: requester 1 accepted first (flags[7]=1), requester 3 next cycle (flags[7]=0). No X appears on flags at any time.
- Bad index with NFLAG=6: set idx 7 accepted -> err=1 for one cycle, flags unchanged, gnt_valid=1, ptr advances.
- en and reset mid-stream: en=0 for 3 cycles with requests pending -> no req_ready, flags hold. Then assert rst during an active grant -> flags=0 and ptr=0 immediately; the pending command is not applied.
